// File: rtl/softreg_host_seq.sv
// SoftReg host sequencer: replays a loadable table of SoftReg writes after a
// start pulse, then polls a completion register until it reads non-zero or
// the polling phase runs out of time.
module softreg_host_seq #(
  parameter int N_CMDS      = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int START_DELAY = 3,
  parameter int POLL_GAP    = 64,
  parameter int TIMEOUT     = 500000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_wr_en,
  input  logic [$clog2(N_CMDS)-1:0] cmd_wr_idx,
  input  logic [ADDR_W-1:0]         cmd_wr_addr,
  input  logic [DATA_W-1:0]         cmd_wr_data,
  input  logic [$clog2(N_CMDS):0]   n_cmds,
  input  logic [ADDR_W-1:0]         done_addr,
  input  logic                      start,
  output logic                      softreg_req_valid,
  output logic                      softreg_req_isWrite,
  output logic [ADDR_W-1:0]         softreg_req_addr,
  output logic [DATA_W-1:0]         softreg_req_data,
  input  logic                      softreg_resp_valid,
  input  logic [DATA_W-1:0]         softreg_resp_data,
  output logic                      busy,
  output logic                      done,
  output logic                      timed_out,
  output logic [DATA_W-1:0]         result,
  output logic [31:0]               poll_count
);

  localparam int IDX_W = $clog2(N_CMDS);
  localparam logic [IDX_W:0] N_MAX   = (IDX_W+1)'(N_CMDS);
  localparam logic [IDX_W:0] IDX_ONE = (IDX_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_DELAY, S_ISSUE, S_POLL_REQ, S_POLL_WAIT, S_GAP
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_mem [N_CMDS];
  logic [DATA_W-1:0] data_mem [N_CMDS];

  logic [IDX_W:0]    n_lat;
  logic [ADDR_W-1:0] done_addr_lat;
  logic [IDX_W:0]    issue_idx, idx_next;
  logic [31:0]       dly_cnt, gap_cnt, tmo_cnt;
  logic              idx_ok, start_acc, polling, resp_hit, tmo_hit;

  // Out-of-range table indices only exist when N_CMDS is not a power of two.
  generate
    if ((1 << IDX_W) > N_CMDS) begin : g_idx_chk
      assign idx_ok = ({1'b0, cmd_wr_idx} < N_MAX);
    end else begin : g_idx_full
      assign idx_ok = 1'b1;
    end
  endgenerate

  // Command table: host writes land only while no sequence is running.
  always_ff @(posedge clk) begin
    if (cmd_wr_en && !busy && idx_ok) begin
      addr_mem[cmd_wr_idx] <= cmd_wr_addr;
      data_mem[cmd_wr_idx] <= cmd_wr_data;
    end
  end

  // Next-state decode; a non-zero response beats a timeout in the same cycle.
  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    polling    = (state == S_POLL_REQ) || (state == S_POLL_WAIT) || (state == S_GAP);
    resp_hit   = (state == S_POLL_WAIT) && softreg_resp_valid && (softreg_resp_data != '0);
    tmo_hit    = polling && (tmo_cnt == 32'(TIMEOUT - 1));
    idx_next   = (state == S_ISSUE) ? issue_idx + IDX_ONE : '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          next_state = S_DELAY;
        end
      end
      S_DELAY: begin
        if (dly_cnt + 32'd1 >= 32'(START_DELAY))
          next_state = (n_lat != '0) ? S_ISSUE : S_POLL_REQ;
      end
      S_ISSUE: begin
        if (issue_idx + IDX_ONE == n_lat) next_state = S_POLL_REQ;
      end
      S_POLL_REQ: next_state = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (softreg_resp_valid)
          next_state = (softreg_resp_data != '0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt + 32'd1 >= 32'(POLL_GAP)) next_state = S_POLL_REQ;
      end
      default: next_state = S_IDLE;
    endcase
    if (tmo_hit && !resp_hit) next_state = S_IDLE;
  end

  // State, counters, status and registered SoftReg request outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      n_lat               <= '0;
      done_addr_lat       <= '0;
      issue_idx           <= '0;
      dly_cnt             <= '0;
      gap_cnt             <= '0;
      tmo_cnt             <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      timed_out           <= 1'b0;
      result              <= '0;
      poll_count          <= '0;
      softreg_req_valid   <= 1'b0;
      softreg_req_isWrite <= 1'b0;
      softreg_req_addr    <= '0;
      softreg_req_data    <= '0;
    end else begin
      state     <= next_state;
      issue_idx <= idx_next;
      dly_cnt   <= (state == S_DELAY) ? dly_cnt + 32'd1 : '0;
      gap_cnt   <= (state == S_GAP) ? gap_cnt + 32'd1 : '0;

      if (start_acc)    tmo_cnt <= '0;
      else if (polling) tmo_cnt <= tmo_cnt + 32'd1;

      if (start_acc) begin
        n_lat         <= (n_cmds > N_MAX) ? N_MAX : n_cmds;
        done_addr_lat <= done_addr;
      end

      if (start_acc) busy <= 1'b1;
      else if (state != S_IDLE && next_state == S_IDLE) busy <= 1'b0;

      if (start_acc)     done <= 1'b0;
      else if (resp_hit) done <= 1'b1;

      if (start_acc)                timed_out <= 1'b0;
      else if (tmo_hit && !resp_hit) timed_out <= 1'b1;

      if (start_acc)     result <= '0;
      else if (resp_hit) result <= softreg_resp_data;

      if (start_acc) poll_count <= '0;
      else if (next_state == S_POLL_REQ && poll_count != '1) poll_count <= poll_count + 32'd1;

      // Request fields are forced to zero whenever the request is not valid.
      softreg_req_valid   <= (next_state == S_ISSUE) || (next_state == S_POLL_REQ);
      softreg_req_isWrite <= (next_state == S_ISSUE);
      if (next_state == S_ISSUE) begin
        softreg_req_addr <= addr_mem[idx_next[IDX_W-1:0]];
        softreg_req_data <= data_mem[idx_next[IDX_W-1:0]];
      end else if (next_state == S_POLL_REQ) begin
        softreg_req_addr <= done_addr_lat;
        softreg_req_data <= '0;
      end else begin
        softreg_req_addr <= '0;
        softreg_req_data <= '0;
      end
    end
  end

endmodule
